// File: rtl/fp_divider.sv
// fp_divider: iterative IEEE-754 single-precision divider (result = a / b).
// A restoring mantissa divider produces one quotient bit per clock. Latency
// is a fixed 28 edges from the accepted start to the done pulse.
// Optional macro FPDIV_SPECIAL_EN adds Inf/NaN classification for
// exponent-255 operands. Without it, that exponent value is used arithmetically.
module fp_divider #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    div_by_zero
);

    localparam int W  = 1 + EXP_W + FRAC_W;  // word width
    localparam int M  = FRAC_W + 1;          // mantissa with hidden bit
    localparam int QW = FRAC_W + 2;          // quotient bits (integer bit first)
    localparam int RW = FRAC_W + 3;          // remainder width
    localparam int XW = EXP_W + 2;           // signed working exponent width
    localparam int CW = $clog2(QW);

    localparam logic [CW-1:0]        LAST_BIT = CW'(QW - 1);
    localparam logic [EXP_W-1:0]     EXP_MAX  = {EXP_W{1'b1}};
    localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ZERO_X   = '0;
    localparam logic signed [XW-1:0] ONE_X    = XW'(1);
    localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORMALIZE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           a_op_q, a_op_d, b_op_q, b_op_d;
    logic                   sign_q, sign_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic [M-1:0]           mb_q, mb_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [QW-1:0]          quo_q, quo_d;
    logic                   spec_q, spec_d;
    logic [W-1:0]           spec_res_q, spec_res_d;
    logic                   spec_dbz_q, spec_dbz_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [W-1:0]           result_q, result_d;
    logic                   dbz_q, dbz_d;

    // Field extraction from the latched operands
    logic                   sa, sb, a_zero, b_zero;
    logic [EXP_W-1:0]       ea, eb;
    logic [FRAC_W-1:0]      fa, fb;
    assign sa     = a_op_q[W-1];
    assign sb     = b_op_q[W-1];
    assign ea     = a_op_q[W-2:FRAC_W];
    assign eb     = b_op_q[W-2:FRAC_W];
    assign fa     = a_op_q[FRAC_W-1:0];
    assign fb     = b_op_q[FRAC_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

`ifdef FPDIV_SPECIAL_EN
    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = (ea == EXP_MAX) && (fa != '0);
    assign b_nan = (eb == EXP_MAX) && (fb != '0);
    assign a_inf = (ea == EXP_MAX) && (fa == '0);
    assign b_inf = (eb == EXP_MAX) && (fb == '0);
`endif

    logic                   cls_spec, cls_dbz;
    logic [W-1:0]           cls_res;

    // Operand classification: decides whether the quotient bypasses the datapath
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cls_spec = 1'b0;
        cls_res  = '0;
        cls_dbz  = 1'b0;
        if (a_zero && b_zero) begin
            cls_spec = 1'b1;
            cls_res  = QNAN;
            cls_dbz  = 1'b1;
        end else if (b_zero) begin
            cls_spec = 1'b1;
            cls_res  = {sa ^ sb, EXP_MAX, {FRAC_W{1'b0}}};
            cls_dbz  = 1'b1;
        end else if (a_zero) begin
            cls_spec = 1'b1;
            cls_res  = '0;
        end
`ifdef FPDIV_SPECIAL_EN
        // Exponent-255 operands take precedence over the zero handling above
        if (a_nan || b_nan || (a_inf && b_inf)) begin
            cls_spec = 1'b1;
            cls_res  = QNAN;
            cls_dbz  = 1'b0;
        end else if (a_inf) begin
            cls_spec = 1'b1;
            cls_res  = {sa ^ sb, EXP_MAX, {FRAC_W{1'b0}}};
            cls_dbz  = 1'b0;
        end else if (b_inf) begin
            cls_spec = 1'b1;
            cls_res  = '0;
            cls_dbz  = 1'b0;
        end
`endif
    end

    // Restoring-division step and normalisation helpers
    logic                   ge;
    logic [RW-1:0]          diff;
    logic signed [XW-1:0]   exp_n;
    logic [FRAC_W-1:0]      frac_n;
    assign ge     = (rem_q >= {2'b00, mb_q});
    assign diff   = ge ? (rem_q - {2'b00, mb_q}) : rem_q;
    assign exp_n  = quo_q[QW-1] ? exp_q : (exp_q - ONE_X);
    assign frac_n = quo_q[QW-1] ? quo_q[FRAC_W:1] : quo_q[FRAC_W-1:0];

    // Next-state logic for the control FSM and datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_op_d     = a_op_q;
        b_op_d     = b_op_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mb_d       = mb_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_dbz_d = spec_dbz_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        dbz_d      = dbz_q;
        case (state_q)
            S_IDLE: begin
                // done_q high means this is the done cycle; start is ignored there
                if (start && !done_q) begin
                    a_op_d  = a;
                    b_op_d  = b;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d     = sa ^ sb;
                exp_d      = XW'(ea) - XW'(eb) + BIAS_X;
                mb_d       = {1'b1, fb};
                rem_d      = {2'b00, 1'b1, fa};
                quo_d      = '0;
                cnt_d      = '0;
                spec_d     = cls_spec;
                spec_res_d = cls_res;
                spec_dbz_d = cls_dbz;
                state_d    = S_DIVIDE;
            end
            S_DIVIDE: begin
                quo_d = {quo_q[QW-2:0], ge};
                rem_d = {diff[RW-2:0], 1'b0};
                if (cnt_q == LAST_BIT) begin
                    state_d = S_NORMALIZE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_NORMALIZE: begin
                if (spec_q) begin
                    result_d = spec_res_q;
                    dbz_d    = spec_dbz_q;
                end else begin
                    dbz_d = 1'b0;
                    if (exp_n >= EXP_INF) begin
                        result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                    end else if (exp_n <= ZERO_X) begin
                        result_d = '0;
                    end else begin
                        result_d = {sign_q, exp_n[EXP_W-1:0], frac_n};
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset (clears mid-operation too)
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_op_q     <= '0;
            b_op_q     <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mb_q       <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            spec_dbz_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_op_q     <= a_op_d;
            b_op_q     <= b_op_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mb_q       <= mb_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_dbz_q <= spec_dbz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed, table-driven bench for fp_divider plus hand-written
// sequences for ignored starts and mid-operation reset.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    fp_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one operation; returns edges from the accepting edge to done.
    // inj_cyc > 0 drives a second start with other operands at that cycle.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_op, input int inj_cyc,
                         output int lat, output bit busy_bad);
        @(negedge clk);
        a = ta; b = tb_op; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        busy_bad = (busy !== 1'b1);
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == inj_cyc) begin
                start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                if (busy !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
        end
        start = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  busy_bad;
        bit  seen_done;

        vecs[0]  = '{"72.25/8.5",   32'h42908000, 32'h41080000, 32'h41080000, 1'b0};
        vecs[1]  = '{"neg/pos",     32'hC2908000, 32'h41080000, 32'hC1080000, 1'b0};
        vecs[2]  = '{"neg/neg",     32'hC2908000, 32'hC1080000, 32'h41080000, 1'b0};
        vecs[3]  = '{"1/3 trunc",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
        vecs[4]  = '{"0/x",         32'h00000000, 32'h41080000, 32'h00000000, 1'b0};
        vecs[5]  = '{"x/0",         32'h41080000, 32'h00000000, 32'h7F800000, 1'b1};
        vecs[6]  = '{"-x/0",        32'hC1080000, 32'h00000000, 32'hFF800000, 1'b1};
        vecs[7]  = '{"overflow",    32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0};
        vecs[8]  = '{"underflow",   32'h00800000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{"0/0",         32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1};
        vecs[10] = '{"-0/x",        32'h80000000, 32'h41080000, 32'h00000000, 1'b0};
        vecs[11] = '{"6/2",         32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy",   32'(busy), 32'h0);
        check("reset_done",   32'(done), 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_dbz",    32'(div_by_zero), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, lat, busy_bad);
            check({vecs[i].name, " latency"}, 32'(lat), 32'd28);
            check({vecs[i].name, " busy"},    32'(busy_bad), 32'h0);
            check({vecs[i].name, " result"},  result, vecs[i].res);
            check({vecs[i].name, " dbz"},     32'(div_by_zero), 32'(vecs[i].dbz));
            @(posedge clk);
            @(negedge clk);
            check({vecs[i].name, " done_pulse"}, 32'(done), 32'h0);
        end

        // Second start at cycle 5 of an operation must be ignored
        do_op(32'h42908000, 32'h41080000, 5, lat, busy_bad);
        check("busy_start latency", 32'(lat), 32'd28);
        check("busy_start result",  result, 32'h41080000);
        check("busy_start busy",    32'(busy_bad), 32'h0);

        // Start raised during the done cycle must be ignored
        start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("done_cycle_start busy", 32'(busy), 32'h0);
        check("done_cycle_start result", result, 32'h41080000);

        // Reset at cycle 10 of an operation aborts it without a done pulse
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset busy",   32'(busy), 32'h0);
        check("midreset done",   32'(done), 32'h0);
        check("midreset result", result, 32'h0);
        check("midreset dbz",    32'(div_by_zero), 32'h0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("midreset no_done", 32'(seen_done), 32'h0);

        // Operation after the aborted one completes normally
        do_op(32'h3F800000, 32'h40400000, 0, lat, busy_bad);
        check("post_reset latency", 32'(lat), 32'd28);
        check("post_reset result",  result, 32'h3EAAAAAA);
        check("post_reset busy",    32'(busy_bad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
